// File: rtl/mcu_bus_if.sv
// MCU parallel-bus slave: synchronises the MCU strobe, issues single-cycle
// register-bank strobes and runs the fpga_ready/fpga_ack four-phase handshake.
module mcu_bus_if #(
  parameter int          SYNC_STAGES = 2,
  parameter int          NUM_REGS    = 17,
  parameter int          RD_TIMEOUT  = 255,
  parameter logic [7:0]  ERR_DATA    = 8'hFF
) (
  input  logic       CLK50,
  input  logic       RST,
  input  logic [7:0] mcu_data_in,
  output logic [7:0] mcu_data_out,
  output logic       mcu_data_oe,
  input  logic [4:0] address,
  input  logic       mcu_mstr,
  input  logic       write_enable,
  output logic       fpga_ready,
  output logic       fpga_ack,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  input  logic       reg_rvalid,
  output logic       timeout_err
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_ACK     = 3'd5;
  localparam logic [2:0] ST_RELEASE = 3'd6;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic                   s, s_rise;

  logic [2:0]    state_q, state_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [7:0]    dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          terr_q, terr_d;
  logic          ready_q, ready_d;
  logic          ack_q, ack_d;
  logic          oe_q, oe_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          in_range;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], mcu_mstr};
    s       = sync_q[SYNC_STAGES-1];
    s_dly_d = s;
    s_rise  = s & ~s_dly_q;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    terr_d   = terr_q;
    in_range = (32'(addr_q) < NUM_REGS);
    cnt_inc  = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (s_rise) begin
          addr_d  = address;
          wdata_d = mcu_data_in;
          we_d    = write_enable;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!in_range) begin
          if (!we_q) dout_d = ERR_DATA;
          state_d = ST_ACK;
        end else begin
          state_d = we_q ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: state_d = ST_ACK;
      ST_READ: begin
        cnt_d   = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // An MCU that has already given up wins over late data or the timeout.
        if (!s) begin
          state_d = ST_RELEASE;
        end else if (reg_rvalid) begin
          dout_d  = reg_rdata;
          state_d = ST_ACK;
        end else if (cnt_inc == CW'(RD_TIMEOUT)) begin
          dout_d  = ERR_DATA;
          terr_d  = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ACK: begin
        if (!s) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are registered decodes of the next state so they are all low in reset.
    ready_d = (state_d == ST_IDLE);
    ack_d   = (state_d == ST_ACK);
    oe_d    = (state_d == ST_ACK) && !we_d;
    wr_d    = (state_d == ST_WRITE);
    rd_d    = (state_d == ST_READ);
  end

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  assign mcu_data_out = dout_q;
  assign mcu_data_oe  = oe_q;
  assign fpga_ready   = ready_q;
  assign fpga_ack     = ack_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign reg_wr       = wr_q;
  assign reg_rd       = rd_q;
  assign timeout_err  = terr_q;

endmodule
